// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch, skid buffer and IF/ID register feeding decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   fetch_stage_if.master        imem,
   output logic [31:0]          instr,
   output logic [31:0]          pc_plus4,
   output logic                 instr_valid,
   output logic [5:0]           opcode
);
   typedef enum logic [1:0] {REQ, WAIT, KILL} state_t;
   state_t state, state_n;
   logic [31:0] pc, pc_n, redir, redir_n, skid, skid_n, skid_pc4, skid_pc4_n, instr_n, pc_plus4_n;
   logic valid_n, accept, ack;
   assign ack = imem.imem_ack;
   assign accept = !stall || !instr_valid;
   assign imem.imem_addr = pc;
   assign imem.imem_req = state != WAIT;
   assign opcode = instr[31:26];
   always_comb begin
      state_n = state;
      pc_n = pc;
      redir_n = redir;
      skid_n = skid;
      skid_pc4_n = skid_pc4;
      instr_n = instr;
      pc_plus4_n = pc_plus4;
      valid_n = instr_valid;
      if (branch_taken) begin
         instr_n = '0;
         valid_n = 1'b0;
         // a pending request without ack must still complete at the old address
         if (state == WAIT || ack) begin
            pc_n = branch_target;
            state_n = REQ;
         end else begin
            redir_n = branch_target;
            state_n = KILL;
         end
      end else begin
         if (!stall) begin
            instr_n = '0;
            valid_n = 1'b0;
         end
         case (state)
            REQ: if (ack) begin
               pc_n = pc + 32'd4;
               if (accept) begin
                  instr_n = imem.imem_rdata;
                  pc_plus4_n = pc + 32'd4;
                  valid_n = 1'b1;
               end else begin
                  skid_n = imem.imem_rdata;
                  skid_pc4_n = pc + 32'd4;
                  state_n = WAIT;
               end
            end
            WAIT: if (accept) begin
               instr_n = skid;
               pc_plus4_n = skid_pc4;
               valid_n = 1'b1;
               state_n = REQ;
            end
            KILL: if (ack) begin
               pc_n = redir;
               state_n = REQ;
            end
            default: state_n = REQ;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= REQ;
         pc <= RESET_PC;
         redir <= '0;
         skid <= '0;
         skid_pc4 <= '0;
         instr <= '0;
         pc_plus4 <= '0;
         instr_valid <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         redir <= redir_n;
         skid <= skid_n;
         skid_pc4 <= skid_pc4_n;
         instr <= instr_n;
         pc_plus4 <= pc_plus4_n;
         instr_valid <= valid_n;
      end
   end
endmodule
